lsu_bus: RTL and testbench
==========================

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, destination register index width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, datapath width; legal values 32 or 64.
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port exe_to_mem_valid  input  1  upstream payload valid.
REQ-007 SHALL have port mem_to_exe_ready  output  1  stage can accept payload.
REQ-008 SHALL have port exe_to_mem_bus  input  2*DATA_WIDTH+REG_ADDR_WIDTH+5  {regW, regAddr, alu_result, store_data, mem_op[3:0]}, MSB first.
REQ-009 SHALL have port mem_to_wb_valid  output  1  writeback payload valid.
REQ-010 SHALL have port wb_to_mem_ready  input  1  writeback accepts payload.
REQ-011 SHALL have port mem_to_wb_bus  output  DATA_WIDTH+REG_ADDR_WIDTH+2  {excp, regW, regAddr, regData}, MSB first.
REQ-012 SHALL have port mem_req_valid  output  1  memory request valid.
REQ-013 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-014 SHALL have port mem_req_wen  output  1  1 = store, 0 = load.
REQ-015 SHALL have port mem_req_addr  output  ADDR_WIDTH  address aligned down to DATA_WIDTH/8 bytes.
REQ-016 SHALL have port mem_req_wdata  output  DATA_WIDTH  store data shifted into byte lanes.
REQ-017 SHALL have port mem_req_wstrb  output  DATA_WIDTH/8  byte write enables, zero for loads.
REQ-018 SHALL have port mem_resp_valid  input  1  response/write-ack valid, single cycle.
REQ-019 SHALL have port mem_resp_rdata  input  DATA_WIDTH  load data, full aligned word.

Function
REQ-020 SHALL decode mem_op: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 lwu, 7 ld, 8 sb, 9 sh, A sw, B sd; codes 6, 7, B with DATA_WIDTH=32 and C-F SHALL behave as none.
REQ-021 SHALL implement FSM IDLE, REQ, WAIT, DONE; payload captured when exe_to_mem_valid && mem_to_exe_ready.
REQ-022 SHALL drive mem_to_exe_ready = (state==IDLE) || (state==DONE && wb_to_mem_ready), combinationally.
REQ-023 SHALL transition on capture: mem_op none -> DONE (regData = alu_result, 1-cycle latency); memory op -> REQ.
REQ-024 SHALL hold mem_req_valid=1 with stable addr/wdata/wstrb/wen throughout REQ; REQ -> WAIT on mem_req_ready.
REQ-025 SHALL in WAIT go to DONE on mem_resp_valid, registering mem_resp_rdata; responses outside WAIT SHALL be ignored.
REQ-026 SHALL for loads select bytes at alu_result low bits and sign-/zero-extend per mem_op to DATA_WIDTH.
REQ-027 SHALL for stores replicate store_data into lanes, wstrb = size mask << offset, and present regData = alu_result.
REQ-028 SHALL assert mem_to_wb_valid only in DONE; DONE -> IDLE on wb_to_mem_ready without new capture, DONE -> REQ/DONE on simultaneous capture (back-to-back, no bubble).
REQ-029 SHALL keep mem_to_wb_bus stable while mem_to_wb_valid && !wb_to_mem_ready.
REQ-030 SHALL define misaligned as offset not a multiple of access size; offset+size never crosses a word when aligned.

Reset
REQ-031 SHALL on rst: state IDLE, mem_req_valid=0, mem_to_wb_valid=0, mem_to_exe_ready=1, excp=0, mem_req_wstrb=0.
REQ-032 SHALL, when rst asserts mid-REQ/WAIT, abandon the transaction and drop mem_req_valid in the next cycle.

Configuration
REQ-033 SHALL with LSU_MISALIGN_EXC_EN defined: misaligned op skips memory, goes straight to DONE with excp=1, regW=0.
REQ-034 SHALL without LSU_MISALIGN_EXC_EN: excp tied 0, misaligned op issued with address aligned down and lanes from low offset bits (truncated data).

Structure
REQ-035 SHALL place mem_op encodings, FSM state encodings and bus field offsets in shared header lsu_defs.vh (package role).
REQ-036 SHALL implement load extraction/extension as sub-module lsu_load_align (combinational), instantiated once.

Verification
REQ-037 SHALL test: add, alu_result=0x1234, mem_op=0, wb ready -> mem_to_wb_valid next cycle, regData=0x1234, no mem_req_valid.
REQ-038 SHALL test: lb addr 0x80000003, rdata 0x80FF_0000 -> req addr 0x80000000, regData=0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-039 SHALL test: sh addr 0x80000002, store_data 0xABCD, mem_req_ready delayed 3 cycles -> wdata 0xABCDABCD, wstrb 0b1100, signals stable all 3 cycles.
REQ-040 SHALL test: wb_to_mem_ready low 5 cycles in DONE -> bus stable, mem_to_exe_ready=0; raise it with exe valid -> back-to-back capture.
REQ-041 SHALL test: lw addr 0x80000002 -> with macro excp=1, regW=0, no request; without macro request to 0x80000000.
REQ-042 SHALL test: rst in WAIT, then stale mem_resp_valid -> ignored, state IDLE, mem_to_wb_valid stays 0.

Source files
------------

// File: rtl/lsu_bus_pkg.sv
// ============================================================================
// Module      : lsu_bus_pkg
// Description : Shared definitions for the load/store unit: mem_op encodings,
//               FSM state encoding, input-bus field layout and op decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_bus_pkg;

    // mem_op encodings (low 4 bits of exe_to_mem_bus)
    localparam logic [3:0] C_OP_NONE = 4'h0;
    localparam logic [3:0] C_OP_LB   = 4'h1;
    localparam logic [3:0] C_OP_LH   = 4'h2;
    localparam logic [3:0] C_OP_LW   = 4'h3;
    localparam logic [3:0] C_OP_LBU  = 4'h4;
    localparam logic [3:0] C_OP_LHU  = 4'h5;
    localparam logic [3:0] C_OP_LWU  = 4'h6;
    localparam logic [3:0] C_OP_LD   = 4'h7;
    localparam logic [3:0] C_OP_SB   = 4'h8;
    localparam logic [3:0] C_OP_SH   = 4'h9;
    localparam logic [3:0] C_OP_SW   = 4'hA;
    localparam logic [3:0] C_OP_SD   = 4'hB;

    // Input bus field layout, LSB upward: mem_op, store_data, alu_result,
    // regAddr, regW. Widths of the data fields follow DATA_WIDTH.
    localparam int C_OP_LSB   = 0;
    localparam int C_OP_WIDTH = 4;

    // Controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Decoded view of a mem_op; size is log2 of the access size in bytes
    typedef struct packed {
        logic       mem;
        logic       is_store;
        logic [1:0] size;
        logic       sext;
    } op_info_t;

    // 64-bit-only encodings decode as "none" on a 32-bit datapath
    function automatic op_info_t decode_op(input logic [3:0] op, input logic wide);
        op_info_t info;
        info = '0;
        case (op)
            C_OP_LB:  begin info.mem = 1'b1; info.size = 2'd0; info.sext = 1'b1; end
            C_OP_LH:  begin info.mem = 1'b1; info.size = 2'd1; info.sext = 1'b1; end
            C_OP_LW:  begin info.mem = 1'b1; info.size = 2'd2; info.sext = 1'b1; end
            C_OP_LBU: begin info.mem = 1'b1; info.size = 2'd0; end
            C_OP_LHU: begin info.mem = 1'b1; info.size = 2'd1; end
            C_OP_LWU: begin info.mem = wide; info.size = 2'd2; end
            C_OP_LD:  begin info.mem = wide; info.size = 2'd3; end
            C_OP_SB:  begin info.mem = 1'b1; info.is_store = 1'b1; info.size = 2'd0; end
            C_OP_SH:  begin info.mem = 1'b1; info.is_store = 1'b1; info.size = 2'd1; end
            C_OP_SW:  begin info.mem = 1'b1; info.is_store = 1'b1; info.size = 2'd2; end
            C_OP_SD:  begin info.mem = wide; info.is_store = wide; info.size = 2'd3; end
            default:  info = '0;
        endcase
        return info;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load-data extraction: shifts the addressed
//               bytes of an aligned word down and sign/zero-extends them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  offset,
    input  logic [1:0]                       size,
    input  logic                             sext,
    output logic [DATA_WIDTH-1:0]            result
);

    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_sign;
    int                    w_nbits;

    // Bring the addressed byte down to lane 0, then fill above the access size
    always_comb begin
        w_shifted = rdata >> {offset, 3'b000};
        w_nbits   = 8 << size;
        case (size)
            2'd0:    w_sign = sext & w_shifted[7];
            2'd1:    w_sign = sext & w_shifted[15];
            2'd2:    w_sign = sext & w_shifted[31];
            default: w_sign = sext & w_shifted[DATA_WIDTH-1];
        endcase
        result = w_shifted;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= w_nbits) begin
                result[i] = w_sign;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_bus.sv
// ============================================================================
// Module      : lsu_bus
// Description : Memory stage of the pipeline. Captures an EXE payload, issues
//               a single load/store request on a valid/ready memory port,
//               aligns load data and hands the result to writeback.
//               Optional feature macro: LSU_MISALIGN_EXC_EN - misaligned
//               accesses raise excp instead of being issued truncated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   exe_to_mem_valid,
    output logic                                   mem_to_exe_ready,
    input  logic [2*DATA_WIDTH+REG_ADDR_WIDTH+4:0] exe_to_mem_bus,
    output logic                                   mem_to_wb_valid,
    input  logic                                   wb_to_mem_ready,
    output logic [DATA_WIDTH+REG_ADDR_WIDTH+1:0]   mem_to_wb_bus,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic                                   mem_req_wen,
    output logic [ADDR_WIDTH-1:0]                  mem_req_addr,
    output logic [DATA_WIDTH-1:0]                  mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]                mem_req_wstrb,
    input  logic                                   mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]                  mem_resp_rdata
);

    import lsu_bus_pkg::*;

    localparam int C_NB    = DATA_WIDTH / 8;
    localparam int C_OFF_W = $clog2(C_NB);

    // Unpacked input payload
    logic                      w_regw;
    logic [REG_ADDR_WIDTH-1:0] w_regaddr;
    logic [DATA_WIDTH-1:0]     w_alu;
    logic [DATA_WIDTH-1:0]     w_sd;
    logic [C_OP_WIDTH-1:0]     w_op;
    op_info_t                  w_info;
    logic [C_OFF_W-1:0]        w_offset;
    logic [ADDR_WIDTH-1:0]     w_addr_raw;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [C_NB-1:0]           w_mask;
    logic [C_NB-1:0]           w_wstrb;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic                      w_capture;
    logic                      w_excp;
    logic [DATA_WIDTH-1:0]     w_load_data;

    // State and registered outputs
    lsu_state_t                r_state;
    logic                      r_req_valid;
    logic                      r_req_wen;
    logic [ADDR_WIDTH-1:0]     r_req_addr;
    logic [DATA_WIDTH-1:0]     r_req_wdata;
    logic [C_NB-1:0]           r_req_wstrb;
    logic                      r_wb_valid;
    logic                      r_regw;
    logic [REG_ADDR_WIDTH-1:0] r_regaddr;
    logic [DATA_WIDTH-1:0]     r_regdata;
    logic [C_OFF_W-1:0]        r_offset;
    logic [1:0]                r_size;
    logic                      r_sext;
    logic                      r_is_store;

    assign {w_regw, w_regaddr, w_alu, w_sd, w_op} = exe_to_mem_bus;
    assign w_info     = decode_op(w_op, 1'(DATA_WIDTH == 64));
    assign w_offset   = w_alu[C_OFF_W-1:0];
    assign w_addr_raw = ADDR_WIDTH'(w_alu);
    assign w_addr     = {w_addr_raw[ADDR_WIDTH-1:C_OFF_W], {C_OFF_W{1'b0}}};

    // A new payload is accepted when idle, or when the current result leaves this cycle
    assign mem_to_exe_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && wb_to_mem_ready);
    assign w_capture        = exe_to_mem_valid && mem_to_exe_ready;

    // Byte-lane mask, shifted to the access offset; a misaligned offset simply
    // loses the lanes that fall past the top of the word
    always_comb begin
        case (w_info.size)
            2'd0:    w_mask = C_NB'(8'h01);
            2'd1:    w_mask = C_NB'(8'h03);
            2'd2:    w_mask = C_NB'(8'h0F);
            default: w_mask = C_NB'(8'hFF);
        endcase
        w_wstrb = w_info.is_store ? (w_mask << w_offset) : '0;
    end

    // Replicate the store data so the addressed lanes carry it at any offset
    always_comb begin
        case (w_info.size)
            2'd0:    w_wdata = {C_NB{w_sd[7:0]}};
            2'd1:    w_wdata = {(C_NB/2){w_sd[15:0]}};
            2'd2:    w_wdata = {(C_NB/4){w_sd[31:0]}};
            default: w_wdata = w_sd;
        endcase
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic [C_OFF_W-1:0] w_size_mask;
    logic               w_misalign;
    logic               r_excp;

    // Offset bits below the access size must be zero for an aligned access
    always_comb begin
        case (w_info.size)
            2'd0:    w_size_mask = '0;
            2'd1:    w_size_mask = C_OFF_W'(1);
            2'd2:    w_size_mask = C_OFF_W'(3);
            default: w_size_mask = C_OFF_W'(7);
        endcase
        w_misalign = |(w_offset & w_size_mask);
    end

    assign w_excp = r_excp;
`else
    assign w_excp = 1'b0;
`endif

    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata  (mem_resp_rdata),
        .offset (r_offset),
        .size   (r_size),
        .sext   (r_sext),
        .result (w_load_data)
    );

    // Controller: capture, request handshake, response wait, writeback hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_valid <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_req_wstrb <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            r_excp      <= 1'b0;
`endif
        end else if (w_capture) begin
            r_regw      <= w_regw;
            r_regaddr   <= w_regaddr;
            r_regdata   <= w_alu;
            r_req_wen   <= w_info.is_store;
            r_req_addr  <= w_addr;
            r_req_wdata <= w_wdata;
            r_req_wstrb <= w_wstrb;
            r_offset    <= w_offset;
            r_size      <= w_info.size;
            r_sext      <= w_info.sext;
            r_is_store  <= w_info.is_store;
`ifdef LSU_MISALIGN_EXC_EN
            r_excp      <= 1'b0;
`endif
            if (!w_info.mem) begin
                r_state     <= S_DONE;
                r_wb_valid  <= 1'b1;
                r_req_valid <= 1'b0;
            end
`ifdef LSU_MISALIGN_EXC_EN
            else if (w_misalign) begin
                r_state     <= S_DONE;
                r_wb_valid  <= 1'b1;
                r_req_valid <= 1'b0;
                r_req_wstrb <= '0;
                r_excp      <= 1'b1;
                r_regw      <= 1'b0;
            end
`endif
            else begin
                r_state     <= S_REQ;
                r_wb_valid  <= 1'b0;
                r_req_valid <= 1'b1;
            end
        end else begin
            case (r_state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_state    <= S_DONE;
                        r_wb_valid <= 1'b1;
                        if (!r_is_store) begin
                            r_regdata <= w_load_data;
                        end
                    end
                end
                S_DONE: begin
                    if (wb_to_mem_ready) begin
                        r_state    <= S_IDLE;
                        r_wb_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid   = r_req_valid;
    assign mem_req_wen     = r_req_wen;
    assign mem_req_addr    = r_req_addr;
    assign mem_req_wdata   = r_req_wdata;
    assign mem_req_wstrb   = r_req_wstrb;
    assign mem_to_wb_valid = r_wb_valid;
    assign mem_to_wb_bus   = {w_excp, r_regw, r_regaddr, r_regdata};

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus.sv
// ============================================================================
// Module      : tb_lsu_bus
// Description : Self-checking bench for lsu_bus: directed vector table,
//               hand-written stall/reset sequences and randomized ops checked
//               against a byte-level reference model.
//               Honours LSU_MISALIGN_EXC_EN when the RTL is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus;

    localparam int RAW = 5;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            exe_to_mem_valid;
    logic            mem_to_exe_ready;
    logic [2*DW+RAW+4:0] exe_to_mem_bus;
    logic            mem_to_wb_valid;
    logic            wb_to_mem_ready;
    logic [DW+RAW+1:0] mem_to_wb_bus;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_req_wen;
    logic [AW-1:0]   mem_req_addr;
    logic [DW-1:0]   mem_req_wdata;
    logic [DW/8-1:0] mem_req_wstrb;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_resp_rdata;

    always #5 clk = ~clk;

    lsu_bus #(
        .REG_ADDR_WIDTH (RAW),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .exe_to_mem_valid (exe_to_mem_valid),
        .mem_to_exe_ready (mem_to_exe_ready),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .wb_to_mem_ready  (wb_to_mem_ready),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_wen      (mem_req_wen),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wdata    (mem_req_wdata),
        .mem_req_wstrb    (mem_req_wstrb),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_rdata   (mem_resp_rdata)
    );

    typedef struct {
        logic        mem;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        excp;
        logic        regw;
        logic [31:0] regdata;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          req_lat;
        exp_t        e;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: works byte by byte from the access size and offset
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] alu,
                                   input logic [31:0] sd, input logic [31:0] rdata);
        exp_t        e;
        int          sz;
        int          off;
        bit          ld;
        bit          st;
        bit          sx;
        logic [31:0] val;
        e.mem = 1'b0; e.wen = 1'b0; e.addr = '0; e.wdata = '0; e.wstrb = '0;
        e.excp = 1'b0; e.regw = 1'b1; e.regdata = alu;
        sz = 1; ld = 0; st = 0; sx = 0;
        case (op)
            4'h1: begin ld = 1; sz = 1; sx = 1; end
            4'h2: begin ld = 1; sz = 2; sx = 1; end
            4'h3: begin ld = 1; sz = 4; sx = 1; end
            4'h4: begin ld = 1; sz = 1; end
            4'h5: begin ld = 1; sz = 2; end
            4'h8: begin st = 1; sz = 1; end
            4'h9: begin st = 1; sz = 2; end
            4'hA: begin st = 1; sz = 4; end
            default: ;
        endcase
        if (!ld && !st) return e;
        off = int'(alu % 32'd4);
`ifdef LSU_MISALIGN_EXC_EN
        if ((off % sz) != 0) begin
            e.excp = 1'b1;
            e.regw = 1'b0;
            return e;
        end
`endif
        e.mem  = 1'b1;
        e.wen  = st;
        e.addr = alu - 32'(off);
        if (st) begin
            for (int b = 0; b < 4; b++) begin
                e.wstrb[b] = (b >= off) && (b < off + sz);
                e.wdata[8*b +: 8] = sd[8*(b % sz) +: 8];
            end
        end else begin
            val = '0;
            for (int k = 0; k < sz; k++) begin
                if (off + k < 4) val[8*k +: 8] = rdata[8*(off+k) +: 8];
            end
            if (sx && sz < 4 && val[8*sz-1]) begin
                for (int i = 8*sz; i < 32; i++) val[i] = 1'b1;
            end
            e.regdata = val;
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                                input logic [31:0] rdata, input int lat, input logic mem, input logic wen,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                                input logic excp, input logic regw, input logic [31:0] regdata);
        vec_t v;
        v.op = op; v.alu = alu; v.sd = sd; v.rdata = rdata; v.req_lat = lat;
        v.e.mem = mem; v.e.wen = wen; v.e.addr = addr; v.e.wdata = wdata; v.e.wstrb = wstrb;
        v.e.excp = excp; v.e.regw = regw; v.e.regdata = regdata;
        return v;
    endfunction

    // One complete transaction with wb_to_mem_ready held high; called at a negedge
    task automatic run_txn(input vec_t v, input string tag);
        logic [4:0] radr;
        radr = 5'($urandom);
        check({tag, " exe_ready"}, 64'(mem_to_exe_ready), 64'd1);
        exe_to_mem_bus   = {1'b1, radr, v.alu, v.sd, v.op};
        exe_to_mem_valid = 1'b1;
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        if (v.e.mem) begin
            for (int k = 0; k <= v.req_lat; k++) begin
                check({tag, " req_valid"}, 64'(mem_req_valid), 64'd1);
                check({tag, " req_addr"},  64'(mem_req_addr),  64'(v.e.addr));
                check({tag, " req_wen"},   64'(mem_req_wen),   64'(v.e.wen));
                check({tag, " req_wstrb"}, 64'(mem_req_wstrb), 64'(v.e.wstrb));
                if (v.e.wen) check({tag, " req_wdata"}, 64'(mem_req_wdata), 64'(v.e.wdata));
                if (k == v.req_lat) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            check({tag, " req_dropped"}, 64'(mem_req_valid), 64'd0);
            check({tag, " wb_early"}, 64'(mem_to_wb_valid), 64'd0);
            mem_resp_rdata = v.rdata;
            mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end else begin
            check({tag, " no_req"}, 64'(mem_req_valid), 64'd0);
        end
        check({tag, " wb_valid"}, 64'(mem_to_wb_valid), 64'd1);
        check({tag, " excp"},     64'(mem_to_wb_bus[DW+RAW+1]), 64'(v.e.excp));
        check({tag, " regw"},     64'(mem_to_wb_bus[DW+RAW]),   64'(v.e.regw));
        check({tag, " regaddr"},  64'(mem_to_wb_bus[DW +: RAW]), 64'(radr));
        if (!v.e.excp) check({tag, " regdata"}, 64'(mem_to_wb_bus[DW-1:0]), 64'(v.e.regdata));
        @(negedge clk);
        check({tag, " wb_clear"}, 64'(mem_to_wb_valid), 64'd0);
    endtask

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; exe_to_mem_valid = 1'b0; exe_to_mem_bus = '0; wb_to_mem_ready = 1'b1;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;

        tbl[0]  = mk(4'h0, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_1234);
        tbl[1]  = mk(4'h1, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'hFFFF_FF80);
        tbl[2]  = mk(4'h4, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1, 1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'h0000_0080);
        tbl[3]  = mk(4'h9, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 3, 1, 1, 32'h8000_0000, 32'hABCD_ABCD, 4'b1100, 0, 1, 32'h8000_0002);
`ifdef LSU_MISALIGN_EXC_EN
        tbl[4]  = mk(4'h3, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
`else
        tbl[4]  = mk(4'h3, 32'h8000_0002, 32'h0, 32'h1122_3344, 0, 1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'h0000_1122);
`endif
        tbl[5]  = mk(4'h3, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2, 1, 0, 32'h8000_0004, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF);
        tbl[6]  = mk(4'h2, 32'h0000_0012, 32'h0, 32'h8001_0000, 0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 32'hFFFF_8001);
        tbl[7]  = mk(4'h5, 32'h0000_0012, 32'h0, 32'h8001_0000, 1, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 0, 1, 32'h0000_8001);
        tbl[8]  = mk(4'h8, 32'h0000_0007, 32'h0000_005A, 32'h0, 0, 1, 1, 32'h0000_0004, 32'h5A5A_5A5A, 4'b1000, 0, 1, 32'h0000_0007);
        tbl[9]  = mk(4'hA, 32'h0000_0100, 32'hCAFE_F00D, 32'h0, 2, 1, 1, 32'h0000_0100, 32'hCAFE_F00D, 4'b1111, 0, 1, 32'h0000_0100);
        tbl[10] = mk(4'h7, 32'h0000_0055, 32'h1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_0055);
        tbl[11] = mk(4'hF, 32'h0000_0066, 32'h1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'h0000_0066);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst req_valid",  64'(mem_req_valid),   64'd0);
        check("rst wb_valid",   64'(mem_to_wb_valid), 64'd0);
        check("rst exe_ready",  64'(mem_to_exe_ready), 64'd1);
        check("rst wstrb",      64'(mem_req_wstrb),   64'd0);
        check("rst excp",       64'(mem_to_wb_bus[DW+RAW+1]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Writeback stall for 5 cycles, then back-to-back capture
        wb_to_mem_ready  = 1'b0;
        exe_to_mem_bus   = {1'b1, 5'd3, 32'h0000_1111, 32'h0, 4'h0};
        exe_to_mem_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall wb_valid",  64'(mem_to_wb_valid), 64'd1);
            check("stall wb_bus",    64'(mem_to_wb_bus), 64'({1'b0, 1'b1, 5'd3, 32'h0000_1111}));
            check("stall exe_ready", 64'(mem_to_exe_ready), 64'd0);
            @(negedge clk);
        end
        wb_to_mem_ready = 1'b1;
        exe_to_mem_bus  = {1'b1, 5'd4, 32'h0000_2222, 32'h0, 4'h0};
        #1;
        check("b2b exe_ready", 64'(mem_to_exe_ready), 64'd1);
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        check("b2b wb_valid", 64'(mem_to_wb_valid), 64'd1);
        check("b2b wb_bus",   64'(mem_to_wb_bus), 64'({1'b0, 1'b1, 5'd4, 32'h0000_2222}));
        @(negedge clk);
        check("b2b wb_clear", 64'(mem_to_wb_valid), 64'd0);

        // Reset while in REQ drops the request next cycle
        exe_to_mem_bus   = {1'b1, 5'd1, 32'h0000_0040, 32'h0, 4'h3};
        exe_to_mem_valid = 1'b1;
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        check("rstreq req_valid", 64'(mem_req_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstreq dropped", 64'(mem_req_valid), 64'd0);
        @(negedge clk);

        // Reset while in WAIT, then a stale response must be ignored
        exe_to_mem_bus   = {1'b1, 5'd2, 32'h0000_0080, 32'h0, 4'h3};
        exe_to_mem_valid = 1'b1;
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        mem_req_ready    = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rstwait in_wait", 64'(mem_req_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstwait wb_valid",  64'(mem_to_wb_valid),  64'd0);
            check("rstwait exe_ready", 64'(mem_to_exe_ready), 64'd1);
            check("rstwait req_valid", 64'(mem_req_valid),    64'd0);
            @(negedge clk);
        end

        // Randomized ops against the reference model
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            v.op      = 4'($urandom_range(0, 15));
            v.alu     = $urandom;
            v.sd      = $urandom;
            v.rdata   = $urandom;
            v.req_lat = $urandom_range(0, 3);
            v.e       = model(v.op, v.alu, v.sd, v.rdata);
            run_txn(v, $sformatf("rand%0d op%0h", n, v.op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
